bus_share_arb8: RTL and testbench

Round-robin scheduler that shares the 32-bit 8:1 data selector (MUX8T1_32) among eight requesters. It grants one requester at a time and drives the mux select `s`. It registers the selected mux output with a valid flag and a source tag, and caps each ownership at `MAX_BURST` cycles. It sits between the eight channel sources and the shared 32-bit consumer (display/bus capture path).

---
 rtl/bus_share_arb8.sv | 129 ++++++++++++
 tb/tb_bus_share_arb8.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_share_arb8.sv
// Round-robin owner of the shared 32-bit 8:1 mux: grants one channel at a time,
// drives the mux select, and registers each owned cycle's mux output with a source tag.
module bus_share_arb8 #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  req,
  input  logic [31:0] mux_o,
  output logic [2:0]  sel,
  output logic [7:0]  gnt,
  output logic        busy,
  output logic [31:0] dout,
  output logic [2:0]  dout_src,
  output logic        dout_vld
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  // Handshake: req[i] is held high by channel i for the whole transfer; gnt[i]
  // answers one cycle later; each cycle with gnt[i] and req[i] both high yields
  // one dout_vld pulse on the following cycle. Dropping req[i] ends the transfer.
  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_d, src_d;
  logic [7:0]    gnt_d;
  logic          busy_d, vld_d;
  logic [31:0]   dout_d;

  logic [2:0]    rr_base;
  logic          win_found;
  logic [2:0]    win_idx;
  logic          owner_req;
  logic          end_cond;

  // While owning, the owner itself is the scan base so it drops to lowest priority.
  always_comb begin
    rr_base   = (state_q == GRANT) ? sel : ptr_q;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      if (!win_found && req[rr_base + 3'(k)]) begin
        win_found = 1'b1;
        win_idx   = rr_base + 3'(k);
      end
    end
  end

  assign owner_req = req[sel];
  assign end_cond  = !owner_req || (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel;
    gnt_d   = gnt;
    busy_d  = busy;
    dout_d  = dout;
    src_d   = dout_src;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 8'b1 << win_idx;
          sel_d   = win_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (owner_req) begin
          dout_d = mux_o;
          src_d  = sel;
          vld_d  = 1'b1;
        end
        if (end_cond) begin
          ptr_d = sel;
          if (win_found) begin
            gnt_d = 8'b1 << win_idx;
            sel_d = win_idx;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 3'd7;
      cnt_q    <= '0;
      sel      <= 3'd0;
      gnt      <= 8'h00;
      busy     <= 1'b0;
      dout     <= 32'h0;
      dout_src <= 3'd0;
      dout_vld <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sel      <= sel_d;
      gnt      <= gnt_d;
      busy     <= busy_d;
      dout     <= dout_d;
      dout_src <= src_d;
      dout_vld <= vld_d;
    end
  end

endmodule

// File: tb/tb_bus_share_arb8.sv
// Bench for bus_share_arb8 (MAX_BURST=4): directed vector table, multi-cycle
// corner sequences, then random traffic against a queue-based reference model.
module tb_bus_share_arb8;

  localparam int MB = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [31:0] mux_o;
  logic [2:0]  sel;
  logic [7:0]  gnt;
  logic        busy;
  logic [31:0] dout;
  logic [2:0]  dout_src;
  logic        dout_vld;

  int n_pass = 0;
  int n_total = 0;

  bus_share_arb8 #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .mux_o(mux_o), .sel(sel), .gnt(gnt),
    .busy(busy), .dout(dout), .dout_src(dout_src), .dout_vld(dout_vld)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_owner;   // -1 when nobody owns the mux
  int          m_ptr;
  int          m_held;    // cycles the current owner has held the grant so far
  int          m_sel;
  logic [31:0] m_dout;
  int          m_src;
  logic        m_vld;
  logic [34:0] exp_q[$];  // {src, data} samples expected on dout

  function automatic int rr_pick(input int base, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(base + k) % 8]) return (base + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] q, input logic [31:0] m);
    int w;
    if (r) begin
      m_owner = -1; m_ptr = 7; m_held = 0; m_sel = 0;
      m_dout = 32'h0; m_src = 0; m_vld = 1'b0;
      exp_q.delete();
    end else if (m_owner < 0) begin
      m_vld = 1'b0;
      w = rr_pick(m_ptr, q);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_held = 0;
      end
    end else begin
      m_vld = 1'b0;
      if (q[m_owner]) begin
        m_dout = m;
        m_src  = m_owner;
        m_vld  = 1'b1;
        exp_q.push_back({3'(m_owner), m});
      end
      m_held++;
      if (!q[m_owner] || m_held >= MB) begin
        m_ptr = m_owner;
        w = rr_pick(m_owner, q);
        m_held = 0;
        if (w >= 0) begin
          m_owner = w; m_sel = w;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  // ---------------- driver / checker ----------------
  task automatic tick(input logic r, input logic [7:0] q, input logic [31:0] m);
    rst = r; req = q; mux_o = m;
    @(posedge clk);
    model_step(r, q, m);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_sel,
                         input logic e_busy, input logic [31:0] e_dout, input logic [2:0] e_src,
                         input logic e_vld);
    chk({tag, "_gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, "_sel"}, 32'(sel), 32'(e_sel));
    chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
    chk({tag, "_dout"}, dout, e_dout);
    chk({tag, "_src"}, 32'(dout_src), 32'(e_src));
    chk({tag, "_vld"}, 32'(dout_vld), 32'(e_vld));
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  req;
    logic [31:0] mux;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        busy;
    logic [31:0] dout;
    logic [2:0]  src;
    logic        vld;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0]  rq;
    logic [7:0]  e_gnt;
    logic [31:0] md;
    logic        rr;

    rst = 1'b1; req = 8'h00; mux_o = 32'h0;

    // rst, req, mux -> gnt, sel, busy, dout, src, vld (after the edge)
    vecs[0]  = '{1'b1, 8'hFF, 32'h0,        8'h00, 3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 32'h0,        8'h00, 3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 32'h0,        8'h01, 3'd0, 1'b1, 32'h0,        3'd0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 32'h0,        8'h00, 3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
    vecs[4]  = '{1'b0, 8'h04, 32'hDEAD0002, 8'h04, 3'd2, 1'b1, 32'h0,        3'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'h04, 32'hDEAD0002, 8'h04, 3'd2, 1'b1, 32'hDEAD0002, 3'd2, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 32'hDEAD0002, 8'h00, 3'd2, 1'b0, 32'hDEAD0002, 3'd2, 1'b0};
    vecs[7]  = '{1'b0, 8'h80, 32'h77770007, 8'h80, 3'd7, 1'b1, 32'hDEAD0002, 3'd2, 1'b0};
    vecs[8]  = '{1'b0, 8'h80, 32'h77770007, 8'h80, 3'd7, 1'b1, 32'h77770007, 3'd7, 1'b1};
    vecs[9]  = '{1'b0, 8'h06, 32'h77770007, 8'h02, 3'd1, 1'b1, 32'h77770007, 3'd7, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 32'h11110001, 8'h00, 3'd1, 1'b0, 32'h77770007, 3'd7, 1'b0};
    vecs[11] = '{1'b1, 8'h00, 32'h0,        8'h00, 3'd0, 1'b0, 32'h0,        3'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].rst, vecs[i].req, vecs[i].mux);
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy,
              vecs[i].dout, vecs[i].src, vecs[i].vld);
    end

    // Burst rotation: channels 0 and 7 alternate every MB cycles with no gap.
    tick(1'b0, 8'h81, 32'hB0000000);
    chk("rot_first_gnt", 32'(gnt), 32'h01);
    for (int k = 1; k <= 4 * MB; k++) begin
      md = 32'hB0000000 | 32'(k);
      tick(1'b0, 8'h81, md);
      e_gnt = (((k / MB) % 2) == 1) ? 8'h80 : 8'h01;
      chk_all($sformatf("rot%0d", k), e_gnt, (e_gnt == 8'h80) ? 3'd7 : 3'd0, 1'b1, md,
              ((((k - 1) / MB) % 2) == 1) ? 3'd7 : 3'd0, 1'b1);
    end

    // Sole requester keeps the mux across burst expiries.
    tick(1'b1, 8'h10, 32'h0);
    tick(1'b0, 8'h10, 32'hC0000000);
    chk("sole_first_gnt", 32'(gnt), 32'h10);
    for (int k = 1; k <= 12; k++) begin
      md = 32'hC0000000 | 32'(k);
      tick(1'b0, 8'h10, md);
      chk_all($sformatf("sole%0d", k), 8'h10, 3'd4, 1'b1, md, 3'd4, 1'b1);
    end

    // Reset mid-grant, then channel 5 regains the mux one cycle after release.
    tick(1'b1, 8'h20, 32'h0);
    tick(1'b0, 8'h20, 32'h55550005);
    chk("mid_gnt_before", 32'(gnt), 32'h20);
    tick(1'b0, 8'h20, 32'h55550005);
    chk("mid_vld_before", 32'(dout_vld), 32'h1);
    tick(1'b1, 8'h20, 32'h55550005);
    chk_all("mid_rst", 8'h00, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0);
    tick(1'b0, 8'h20, 32'h55550005);
    chk_all("mid_after", 8'h20, 3'd5, 1'b1, 32'h0, 3'd0, 1'b0);

    // Random traffic against the reference model and sample scoreboard.
    tick(1'b1, 8'h00, 32'h0);
    rq = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      rr = ($urandom_range(0, 249) == 0);
      tick(rr, rq, $urandom());
      chk("rnd_gnt", 32'(gnt), (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
      chk("rnd_sel", 32'(sel), 32'(m_sel));
      chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
      chk("rnd_vld", 32'(dout_vld), 32'(m_vld));
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_sample", 32'(dout_vld), 32'h0);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          chk("rnd_dout", dout, e[31:0]);
          chk("rnd_src", 32'(dout_src), 32'(e[34:32]));
        end
      end
    end
    chk("rnd_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
